mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Target-side end of the single-outstanding valid/ready memory bus driven by the layer data loaders (rvalid/raddr → rready/rdata; wvalid/waddr/wdata → wready).
- Accepts one request at a time and executes it on a single-port synchronous SRAM (1-cycle read latency), with programmable wait states.
- Returns exactly one ready pulse per request. Sits between the loader and on-chip buffer SRAM; also serves as the bench memory model.

Parameters:
- ADDR_W, 16, SRAM address width
- DEPTH, 65536, number of valid words; bus addresses ≥ DEPTH are out of range
- LATENCY, 2, extra wait cycles inserted before each ready pulse (0..15)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rvalid  in  1  read request, held high until rready seen
- raddr  in  26  read word address
- rready  out  1  one-cycle read acknowledge; rdata valid in the same cycle
- rdata  out  32  read data
- wvalid  in  1  write request, held high until wready seen
- waddr  in  26  write word address
- wdata  in  32  write data
- wready  out  1  one-cycle write acknowledge
- mem_ce  out  1  SRAM access strobe
- mem_we  out  1  SRAM write enable, qualified by mem_ce
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_ce && !mem_we
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky out-of-range flag; cleared only by reset

Behaviour:
- All outputs are registered. On reset (async, rst=0), every output is 0 and the state is IDLE, including mid-transaction; the in-flight request is dropped.
- States: IDLE, ISSUE, WAIT, ACK, GAP.
- IDLE:
  - Samples wvalid/rvalid. If both are high, the write wins.
  - Latches the address, write data and direction.
  - In-range request → ISSUE. Out-of-range request → ACK directly, with rdata=0, no SRAM access, err set.
- ISSUE (1 cycle): mem_ce=1, mem_we=dir, mem_addr=addr[ADDR_W-1:0], mem_wdata=latched data.
- WAIT (LATENCY+1 cycles):
  - The down-counter is loaded with LATENCY on entry.
  - For reads, rdata_r captures mem_rdata at the end of the first WAIT cycle.
- ACK (exactly 1 cycle): rready=1 for reads or wready=1 for writes; rdata is held until the next read capture.
- GAP: stay while the served valid is still high; go to IDLE once it is low. A held request is never served twice.
- Latency, with valid first seen in cycle t:
  - In-range: ready high in cycle t+3+LATENCY.
  - Out-of-range: ready high in cycle t+1.
- Address check: in range iff addr < DEPTH. The comparison is 26-bit unsigned.
- A valid that drops before its ready is a protocol violation; the transaction completes regardless.
- A request arriving on the other channel while busy waits in IDLE arbitration; no request is lost.
- mem_addr and mem_wdata hold their last values outside ISSUE; mem_we is 0 outside ISSUE.

Decomposition:
- Shared package: state encoding, BUS_ADDR_W=26, BUS_DATA_W=32, DIR_READ/DIR_WRITE constants.
- No synthesisable sub-module; FSM and datapath live in one module.
- A behavioural sync_sram (DEPTH×32, 1-cycle read) is a bench-only sub-module.

Test Plan:
- Write then read, LATENCY=2:
  - waddr=0x10, wdata=0xDEADBEEF at t → mem_ce/mem_we high at t+1, wready high only at t+5.
  - Read of 0x10 → rready with rdata=0xDEADBEEF exactly one cycle.
- Simultaneous rvalid/wvalid in IDLE → write acknowledged first, read acknowledged after GAP, both exactly once; SRAM holds the written value.
- Out of range: raddr=DEPTH → rready at t+1 with rdata=0, mem_ce never asserted, err=1 and stays 1 through further legal traffic.
- Back-to-back reads of addresses 0..63 with LATENCY=0, following the initiator protocol → 64 rready pulses, each 3 cycles after its rvalid; data matches preload; no duplicate acknowledges.
- Reset asserted during WAIT → all outputs 0 asynchronously; after release, a new read completes normally with correct latency.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the single-outstanding memory responder:
// bus widths, FSM state encoding and transfer direction.
package mem_responder_pkg;

    localparam int unsigned BUS_ADDR_W = 26;
    localparam int unsigned BUS_DATA_W = 32;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_GAP
    } state_e;

    // Unsigned bus-address range test; depth carries one extra bit so 2**BUS_ADDR_W fits.
    function automatic logic addr_in_range(input logic [BUS_ADDR_W-1:0] addr,
                                           input logic [BUS_ADDR_W:0]   depth);
        return ({1'b0, addr} < depth);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Loader-to-responder valid/ready bus: one read channel and one write channel,
// each with a single-cycle acknowledge.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic                  rvalid;
    logic [BUS_ADDR_W-1:0] raddr;
    logic                  rready;
    logic [BUS_DATA_W-1:0] rdata;
    logic                  wvalid;
    logic [BUS_ADDR_W-1:0] waddr;
    logic [BUS_DATA_W-1:0] wdata;
    logic                  wready;

    modport master (
        output rvalid, raddr, wvalid, waddr, wdata,
        input  rready, rdata, wready
    );

    modport slave (
        input  rvalid, raddr, wvalid, waddr, wdata,
        output rready, rdata, wready
    );

endinterface

// File: rtl/mem_responder.sv
// Target side of the loader memory bus: serves one request at a time on a
// single-port synchronous SRAM with programmable wait states; all outputs registered.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DEPTH   = 65536,
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_responder_if.slave        bus,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [BUS_DATA_W-1:0] mem_wdata,
    input  logic [BUS_DATA_W-1:0] mem_rdata,
    output logic                  busy,
    output logic                  err
);

    localparam logic [BUS_ADDR_W:0] DEPTH_L = (BUS_ADDR_W+1)'(DEPTH);
    localparam logic [3:0]          LAT_L   = 4'(LATENCY);

    state_e                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BUS_DATA_W-1:0] data_q, data_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  oor_go;

    logic                  mem_ce_q, mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [BUS_DATA_W-1:0] mem_wdata_q;
    logic                  rready_q, wready_q;
    logic [BUS_DATA_W-1:0] rdata_q;
    logic                  busy_q, err_q;

    logic                  req_hit;
    logic                  served_valid;
    logic                  capture_rd;

    assign served_valid = (dir_q == DIR_WRITE) ? bus.wvalid : bus.rvalid;
    // Counter still holds its load value only during the first WAIT cycle,
    // which is when the SRAM read data is valid.
    assign capture_rd   = (state_q == S_WAIT) && (cnt_q == LAT_L) && (dir_q == DIR_READ);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        req_hit = 1'b0;
        oor_go  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.wvalid) begin
                    dir_d   = DIR_WRITE;
                    addr_d  = bus.waddr[ADDR_W-1:0];
                    data_d  = bus.wdata;
                    req_hit = addr_in_range(bus.waddr, DEPTH_L);
                end else if (bus.rvalid) begin
                    dir_d   = DIR_READ;
                    addr_d  = bus.raddr[ADDR_W-1:0];
                    req_hit = addr_in_range(bus.raddr, DEPTH_L);
                end
                if (bus.wvalid || bus.rvalid) begin
                    if (req_hit) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_ACK;
                        oor_go  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = LAT_L;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                if (!served_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_READ;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rready_q    <= 1'b0;
            wready_q    <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_ce_q <= (state_d == S_ISSUE);
            mem_we_q <= (state_d == S_ISSUE) && (dir_d == DIR_WRITE);
            if (state_d == S_ISSUE) begin
                mem_addr_q  <= addr_d;
                mem_wdata_q <= data_d;
            end
            rready_q <= (state_d == S_ACK) && (dir_d == DIR_READ);
            wready_q <= (state_d == S_ACK) && (dir_d == DIR_WRITE);
            if (oor_go && (dir_d == DIR_READ)) begin
                rdata_q <= '0;
            end else if (capture_rd) begin
                rdata_q <= mem_rdata;
            end
            busy_q <= (state_d != S_IDLE);
            err_q  <= err_q | oor_go;
        end
    end

    assign mem_ce     = mem_ce_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign bus.rready = rready_q;
    assign bus.wready = wready_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (LATENCY=2 and LATENCY=0),
// each backed by a behavioural 1-cycle synchronous SRAM.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mem_responder_if bus2();
    mem_responder_if bus0();

    logic        ce2, we2, busy2, err2;
    logic [15:0] addr2;
    logic [31:0] wd2, rd2;
    logic        ce0, we0, busy0, err0;
    logic [15:0] addr0;
    logic [31:0] wd0, rd0;

    mem_responder #(.ADDR_W(16), .DEPTH(65536), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .mem_ce(ce2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2),
        .mem_rdata(rd2), .busy(busy2), .err(err2)
    );

    mem_responder #(.ADDR_W(16), .DEPTH(65536), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .mem_ce(ce0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .mem_rdata(rd0), .busy(busy0), .err(err0)
    );

    logic [31:0] mem2 [0:65535];
    logic [31:0] mem0 [0:65535];
    logic        ld = 1'b0;
    logic [15:0] ld_a = '0;
    logic [31:0] ld_d = '0;
    int          ce2_cnt = 0;
    int          rr0_cnt = 0;

    always @(posedge clk) begin
        if (ce2) begin
            if (we2) mem2[addr2] <= wd2;
            else     rd2 <= mem2[addr2];
        end
        ce2_cnt <= ce2_cnt + (ce2 ? 1 : 0);
    end

    always @(posedge clk) begin
        if (ld) mem0[ld_a] <= ld_d;
        if (ce0) begin
            if (we0) mem0[addr0] <= wd0;
            else     rd0 <= mem0[addr0];
        end
        rr0_cnt <= rr0_cnt + (bus0.rready ? 1 : 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read on bus0 (sel=1) or bus2 (sel=0); the initiator drops rvalid the cycle after rready.
    task automatic rd(input bit sel, input logic [25:0] a, input int exp_lat,
                      input logic [31:0] exp_d, input string tag);
        int   n;
        logic got;
        if (sel) begin bus0.rvalid = 1'b1; bus0.raddr = a; end
        else     begin bus2.rvalid = 1'b1; bus2.raddr = a; end
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            step();
            n++;
            got = sel ? bus0.rready : bus2.rready;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " rdata"}, sel ? bus0.rdata : bus2.rdata, exp_d);
        step();
        if (sel) bus0.rvalid = 1'b0;
        else     bus2.rvalid = 1'b0;
        check({tag, " single_ack"}, {31'd0, sel ? bus0.rready : bus2.rready}, 32'd0);
        step();
    endtask

    initial begin
        int n;
        int c;
        bus2.rvalid = 1'b0; bus2.raddr = '0; bus2.wvalid = 1'b0; bus2.waddr = '0; bus2.wdata = '0;
        bus0.rvalid = 1'b0; bus0.raddr = '0; bus0.wvalid = 1'b0; bus0.waddr = '0; bus0.wdata = '0;

        for (int i = 0; i < 64; i++) begin
            ld   = 1'b1;
            ld_a = 16'(i);
            ld_d = 32'hC0DE_0000 | 32'(i);
            step();
        end
        ld = 1'b0;

        check("rst rready", {31'd0, bus2.rready}, 32'd0);
        check("rst wready", {31'd0, bus2.wready}, 32'd0);
        check("rst rdata", bus2.rdata, 32'd0);
        check("rst mem_ce", {31'd0, ce2}, 32'd0);
        check("rst busy", {31'd0, busy2}, 32'd0);
        check("rst err", {31'd0, err2}, 32'd0);
        check("rst mem_addr", {16'd0, addr2}, 32'd0);
        rst = 1'b1;
        step();

        // Write 0x10 <- DEADBEEF, cycle-accurate
        bus2.wvalid = 1'b1; bus2.waddr = 26'h10; bus2.wdata = 32'hDEAD_BEEF;
        step();
        check("wr t1 mem_ce", {31'd0, ce2}, 32'd1);
        check("wr t1 mem_we", {31'd0, we2}, 32'd1);
        check("wr t1 mem_addr", {16'd0, addr2}, 32'h10);
        check("wr t1 mem_wdata", wd2, 32'hDEAD_BEEF);
        check("wr t1 busy", {31'd0, busy2}, 32'd1);
        check("wr t1 wready", {31'd0, bus2.wready}, 32'd0);
        step();
        check("wr t2 mem_ce", {31'd0, ce2}, 32'd0);
        check("wr t2 mem_we", {31'd0, we2}, 32'd0);
        check("wr t2 mem_addr hold", {16'd0, addr2}, 32'h10);
        step();
        step();
        check("wr t4 wready", {31'd0, bus2.wready}, 32'd0);
        step();
        check("wr t5 wready", {31'd0, bus2.wready}, 32'd1);
        step();
        bus2.wvalid = 1'b0;
        check("wr t6 wready", {31'd0, bus2.wready}, 32'd0);
        step();

        rd(1'b0, 26'h10, 5, 32'hDEAD_BEEF, "rd 0x10");

        // Simultaneous read and write of 0x20: write served first
        bus2.wvalid = 1'b1; bus2.waddr = 26'h20; bus2.wdata = 32'h1234_5678;
        bus2.rvalid = 1'b1; bus2.raddr = 26'h20;
        n = 0;
        while (!bus2.wready && n < 40) begin step(); n++; end
        check("sim wr latency", 32'(n), 32'd5);
        check("sim rd not yet", {31'd0, bus2.rready}, 32'd0);
        step();
        bus2.wvalid = 1'b0;
        check("sim wr single_ack", {31'd0, bus2.wready}, 32'd0);
        n = 0;
        while (!bus2.rready && n < 40) begin step(); n++; end
        check("sim rd latency", 32'(n), 32'd6);
        check("sim rd rdata", bus2.rdata, 32'h1234_5678);
        step();
        bus2.rvalid = 1'b0;
        check("sim rd single_ack", {31'd0, bus2.rready}, 32'd0);
        check("sim wr no dup", {31'd0, bus2.wready}, 32'd0);
        step();
        check("sim sram word", mem2[16'h20], 32'h1234_5678);

        // Out of range
        c = ce2_cnt;
        rd(1'b0, 26'd65536, 1, 32'd0, "oor");
        check("oor no mem_ce", 32'(ce2_cnt), 32'(c));
        check("oor err", {31'd0, err2}, 32'd1);
        rd(1'b0, 26'h20, 5, 32'h1234_5678, "post-oor rd");
        check("oor err sticky", {31'd0, err2}, 32'd1);

        // Back-to-back reads on the zero-latency instance
        for (int i = 0; i < 64; i++) begin
            rd(1'b1, 26'(i), 3, 32'hC0DE_0000 | 32'(i), "b2b");
        end
        check("b2b rready count", 32'(rr0_cnt), 32'd64);
        check("b2b err", {31'd0, err0}, 32'd0);

        // Reset during WAIT
        bus2.rvalid = 1'b1; bus2.raddr = 26'h10;
        step();
        step();
        check("rstw busy pre", {31'd0, busy2}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstw busy", {31'd0, busy2}, 32'd0);
        check("rstw err", {31'd0, err2}, 32'd0);
        check("rstw rdata", bus2.rdata, 32'd0);
        check("rstw mem_addr", {16'd0, addr2}, 32'd0);
        check("rstw mem_wdata", wd2, 32'd0);
        check("rstw mem_ce", {31'd0, ce2}, 32'd0);
        bus2.rvalid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("rstw rready idle", {31'd0, bus2.rready}, 32'd0);
        rd(1'b0, 26'h10, 5, 32'hDEAD_BEEF, "post-rst rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
